// File: rtl/serial_sub.sv
// serial_sub: digit-serial WIDTH-bit subtractor, d_out = d0 - d1 - b_in, DIGIT bits per clock through
// one borrow-ripple slice (LSB digit first), with valid/ready handshakes on both sides.
module serial_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             b_in,
    input  logic             enable,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d_out,
    output logic             b_out,
    output logic             zero,
    output logic             ovf
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, nextState;

    logic [WIDTH-1:0] opA, opB, result, nextResult;
    logic             signA, signB, enReg, borrow;
    logic [CNT_W-1:0] cnt;
    logic [DIGIT:0]   sliceWide;
    logic             lastStep, accept;

    assign accept   = in_valid && in_ready;
    assign lastStep = (cnt == LAST_STEP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (accept) nextState = RUN;
            RUN:     if (lastStep) nextState = DONE;
            DONE:    if (out_ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
    end

    // Operands shift right one digit per step so the slice always reads the low digit; the new
    // result digit enters at the top, so after STEPS shifts the result is aligned.
    always_comb begin
        sliceWide  = {1'b0, opA[DIGIT-1:0]} - {1'b0, opB[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow};
        nextResult = (result >> DIGIT) | (WIDTH'(sliceWide[DIGIT-1:0]) << (WIDTH - DIGIT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opA    <= '0;
            opB    <= '0;
            signA  <= 1'b0;
            signB  <= 1'b0;
            enReg  <= 1'b0;
            borrow <= 1'b0;
            cnt    <= '0;
            result <= '0;
            d_out  <= '0;
            b_out  <= 1'b0;
            zero   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        opA    <= d0;
                        opB    <= d1;
                        signA  <= d0[WIDTH-1];
                        signB  <= d1[WIDTH-1];
                        enReg  <= enable;
                        borrow <= b_in;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    opA    <= opA >> DIGIT;
                    opB    <= opB >> DIGIT;
                    borrow <= sliceWide[DIGIT];
                    result <= nextResult;
                    cnt    <= cnt + 1'b1;
                    // Flags come from the raw difference; only d_out honours enable.
                    if (lastStep) begin
                        d_out <= enReg ? nextResult : '0;
                        b_out <= sliceWide[DIGIT];
                        zero  <= (nextResult == '0);
                        ovf   <= (signA != signB) && (nextResult[WIDTH-1] != signA);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_sub.sv
// Bench for serial_sub: directed vectors push expected results into per-instance queues; monitors
// pop and compare on each output handshake. Two instances cover DIGIT=2 and DIGIT=WIDTH.
module tb_serial_sub;
    typedef struct packed {
        logic [7:0] d;
        logic       b;
        logic       z;
        logic       o;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       sInValid, sInReady, sBIn, sEnable, sOutValid, sOutReady, sBOut, sZero, sOvf;
    logic [7:0] sD0, sD1, sDOut;
    logic       wInValid, wInReady, wBIn, wEnable, wOutValid, wOutReady, wBOut, wZero, wOvf;
    logic [7:0] wD0, wD1, wDOut;

    exp_t sQ[$];
    exp_t wQ[$];
    int   testsRun = 0;
    int   testsFailed = 0;

    serial_sub #(.WIDTH(8), .DIGIT(2)) dutSerial (
        .clk(clk), .rst(rst), .in_valid(sInValid), .in_ready(sInReady), .d0(sD0), .d1(sD1),
        .b_in(sBIn), .enable(sEnable), .out_valid(sOutValid), .out_ready(sOutReady),
        .d_out(sDOut), .b_out(sBOut), .zero(sZero), .ovf(sOvf)
    );

    serial_sub #(.WIDTH(8), .DIGIT(8)) dutWhole (
        .clk(clk), .rst(rst), .in_valid(wInValid), .in_ready(wInReady), .d0(wD0), .d1(wD1),
        .b_in(wBIn), .enable(wEnable), .out_valid(wOutValid), .out_ready(wOutReady),
        .d_out(wDOut), .b_out(wBOut), .zero(wZero), .ovf(wOvf)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    function automatic exp_t mkExp(input logic [7:0] d, input logic b, input logic z, input logic o);
        exp_t e;
        e.d = d;
        e.b = b;
        e.z = z;
        e.o = o;
        return e;
    endfunction

    function automatic exp_t modelSub(input logic [7:0] a, input logic [7:0] b, input logic bi, input logic en);
        exp_t e;
        logic [7:0] diff;
        diff = a - b - {7'd0, bi};
        e.d  = en ? diff : 8'h00;
        e.b  = (int'(a) < int'(b) + int'(bi));
        e.z  = (diff == 8'h00);
        e.o  = (a[7] != b[7]) && (diff[7] != a[7]);
        return e;
    endfunction

    always @(negedge clk) begin : monSerial
        exp_t e;
        if (!rst && sOutValid && sOutReady) begin
            if (sQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL serial unexpected result: d_out 0x%0h with nothing pending", sDOut);
            end else begin
                e = sQ.pop_front();
                checkOutput("serial d_out", 32'(sDOut), 32'(e.d));
                checkOutput("serial b_out", 32'(sBOut), 32'(e.b));
                checkOutput("serial zero", 32'(sZero), 32'(e.z));
                checkOutput("serial ovf", 32'(sOvf), 32'(e.o));
            end
        end
    end

    always @(negedge clk) begin : monWhole
        exp_t e;
        if (!rst && wOutValid && wOutReady) begin
            if (wQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL whole unexpected result: d_out 0x%0h with nothing pending", wDOut);
            end else begin
                e = wQ.pop_front();
                checkOutput("whole d_out", 32'(wDOut), 32'(e.d));
                checkOutput("whole b_out", 32'(wBOut), 32'(e.b));
                checkOutput("whole zero", 32'(wZero), 32'(e.z));
                checkOutput("whole ovf", 32'(wOvf), 32'(e.o));
            end
        end
    end

    task automatic applyStimulus(input bit wide, input logic [7:0] a, input logic [7:0] b,
                                 input logic bi, input logic en, input exp_t expd, input bit push);
        int    guard = 0;
        string tag = wide ? "whole" : "serial";
        while (!(wide ? wInReady : sInReady) && guard < 40) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checkOutput($sformatf("%s in_ready", tag), 32'(wide ? wInReady : sInReady), 32'd1);
        if (wide) begin
            wD0 = a; wD1 = b; wBIn = bi; wEnable = en; wInValid = 1'b1;
            if (push) wQ.push_back(expd);
        end else begin
            sD0 = a; sD1 = b; sBIn = bi; sEnable = en; sInValid = 1'b1;
            if (push) sQ.push_back(expd);
        end
        @(posedge clk);
        #1;
        if (wide) begin
            wInValid = 1'b0; wD0 = ~a; wD1 = ~b; wBIn = ~bi; wEnable = ~en;
        end else begin
            sInValid = 1'b0; sD0 = ~a; sD1 = ~b; sBIn = ~bi; sEnable = ~en;
        end
    endtask

    // Counts edges with the accepting edge as the first one.
    task automatic checkLatency(input bit wide, input int expected);
        int    n = 1;
        string tag = wide ? "whole" : "serial";
        while (!(wide ? wOutValid : sOutValid) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput($sformatf("%s latency", tag), 32'(n), 32'(expected));
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] ra, rb;
        logic       rbi, ren;
        int         guard;

        rst = 1'b1;
        sInValid = 1'b0; sD0 = 8'h00; sD1 = 8'h00; sBIn = 1'b0; sEnable = 1'b0; sOutReady = 1'b1;
        wInValid = 1'b0; wD0 = 8'h00; wD1 = 8'h00; wBIn = 1'b0; wEnable = 1'b0; wOutReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset in_ready", 32'(sInReady), 32'd0);
        checkOutput("reset out_valid", 32'(sOutValid), 32'd0);
        checkOutput("reset d_out", 32'(sDOut), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("in_ready after reset", 32'(sInReady), 32'd1);

        applyStimulus(1'b0, 8'h35, 8'h12, 1'b0, 1'b1, mkExp(8'h23, 1'b0, 1'b0, 1'b0), 1'b1);
        checkLatency(1'b0, 5);
        applyStimulus(1'b0, 8'h00, 8'h01, 1'b0, 1'b1, mkExp(8'hFF, 1'b1, 1'b0, 1'b0), 1'b1);
        applyStimulus(1'b0, 8'h80, 8'h01, 1'b0, 1'b1, mkExp(8'h7F, 1'b0, 1'b0, 1'b1), 1'b1);
        applyStimulus(1'b0, 8'h10, 8'h0F, 1'b1, 1'b1, mkExp(8'h00, 1'b0, 1'b1, 1'b0), 1'b1);
        applyStimulus(1'b0, 8'h35, 8'h12, 1'b0, 1'b0, mkExp(8'h00, 1'b0, 1'b0, 1'b0), 1'b1);

        // Consumer stalls in DONE while a stray in_valid pulse arrives.
        applyStimulus(1'b0, 8'hA0, 8'h30, 1'b0, 1'b1, mkExp(8'h70, 1'b0, 1'b0, 1'b1), 1'b1);
        sOutReady = 1'b0;
        checkLatency(1'b0, 5);
        for (int i = 0; i < 6; i++) begin
            sInValid = (i == 2);
            sD0 = 8'hFF;
            sD1 = 8'h00;
            @(posedge clk);
            #1;
            checkOutput("hold out_valid", 32'(sOutValid), 32'd1);
            checkOutput("hold d_out", 32'(sDOut), 32'h70);
            checkOutput("hold ovf", 32'(sOvf), 32'd1);
            checkOutput("hold in_ready", 32'(sInReady), 32'd0);
        end
        sInValid = 1'b0;
        sOutReady = 1'b1;
        applyStimulus(1'b0, 8'h35, 8'h12, 1'b0, 1'b1, mkExp(8'h23, 1'b0, 1'b0, 1'b0), 1'b1);

        // Abort mid-RUN; the discarded operation must never surface.
        applyStimulus(1'b0, 8'h55, 8'h11, 1'b0, 1'b1, mkExp(8'h44, 1'b0, 1'b0, 1'b0), 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("in_ready during rst", 32'(sInReady), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("abort in_ready", 32'(sInReady), 32'd1);
        checkOutput("abort out_valid", 32'(sOutValid), 32'd0);
        checkOutput("abort d_out", 32'(sDOut), 32'd0);
        checkOutput("abort b_out", 32'(sBOut), 32'd0);
        checkOutput("abort zero", 32'(sZero), 32'd0);
        checkOutput("abort ovf", 32'(sOvf), 32'd0);
        repeat (8) @(posedge clk);
        #1;
        applyStimulus(1'b0, 8'h35, 8'h12, 1'b0, 1'b1, mkExp(8'h23, 1'b0, 1'b0, 1'b0), 1'b1);

        applyStimulus(1'b1, 8'h01, 8'h02, 1'b0, 1'b1, mkExp(8'hFF, 1'b1, 1'b0, 1'b0), 1'b1);
        checkLatency(1'b1, 2);

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom); ren = 1'($urandom);
            applyStimulus(1'b1, ra, rb, rbi, ren, modelSub(ra, rb, rbi, ren), 1'b1);
        end
        for (int i = 0; i < 100; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom); ren = 1'($urandom);
            applyStimulus(1'b0, ra, rb, rbi, ren, modelSub(ra, rb, rbi, ren), 1'b1);
        end

        guard = 0;
        while ((sQ.size() != 0 || wQ.size() != 0) && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checkOutput("serial queue drained", 32'(sQ.size()), 32'd0);
        checkOutput("whole queue drained", 32'(wQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
